// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I instruction fetch stage.
//   NOP_INSTR        : addi x0,x0,0, placed on id_ir whenever IF/ID is empty
//   RESET_PC_DEFAULT : first fetch address after reset
//   fetch_state_t    : fetch FSM encodings (FS_REQ / FS_WAIT / FS_HOLD)
//   word_align       : clears bits [1:0] of a byte address
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,  // ready to issue a request
    FS_WAIT = 2'd1,  // one request outstanding
    FS_HOLD = 2'd2   // response parked in the buffer, IF/ID blocked
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop the held instruction (highest priority after rst)
//   load          : capture load_pc / load_ir as a live instruction
//   stall         : hold a live instruction
//   load_pc/ir    : new entry
//   id_valid, id_pc, id_pc_plus4, id_ir : decode-side outputs
// When the register empties, id_ir becomes NOP_INSTR while id_pc and
// id_pc_plus4 keep their last values.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        stall,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_ir,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_ir
);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_ir       <= NOP;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_ir    <= NOP;
    end else if (load) begin
      id_valid    <= 1'b1;
      id_pc       <= load_pc;
      id_pc_plus4 <= load_pc + 32'd4;
      id_ir       <= load_ir;
    end else if (!stall) begin
      // Nothing new arrived: the old instruction moves on to decode.
      id_valid <= 1'b0;
      id_ir    <= NOP;
    end
    // stall without load: hold everything
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the pipelined RV32I core.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   stall                           : hazard unit holds IF/ID
//   redirect_valid, redirect_pc     : taken branch/jump, flush and refetch
//   imem_req_valid/ready, imem_addr : request channel
//   imem_rsp_valid, imem_rsp_data   : response channel
//   id_valid, id_pc, id_pc_plus4, id_ir : IF/ID outputs to decode
// Handshake: a request transfers on the cycle imem_req_valid && imem_req_ready;
// exactly one response follows at least one cycle later. Only one request is
// ever outstanding. The FSM state is the internal signal 'state'.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_ir
);

  fetch_state_t state, state_next;

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        kill;        // outstanding response belongs to a flushed path
  logic [31:0] buf_pc;
  logic [31:0] buf_ir;

  logic        req_fire;
  logic        rsp_take;    // live response accepted this cycle
  logic        if_id_free;
  logic        buf_store;
  logic        load;
  logic [31:0] load_pc;
  logic [31:0] load_ir;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FS_REQ;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      // A pending response with nothing arriving must still be drained (kill).
      state_next = (state == FS_WAIT && !imem_rsp_valid) ? FS_WAIT : FS_REQ;
    end else begin
      case (state)
        FS_REQ:  if (req_fire) state_next = FS_WAIT;
        FS_WAIT: if (imem_rsp_valid) state_next = (kill || if_id_free) ? FS_REQ : FS_HOLD;
        FS_HOLD: if (!stall) state_next = FS_REQ;
        default: state_next = FS_REQ;
      endcase
    end
  end

  // Output / control logic
  always_comb begin
    imem_req_valid = (state == FS_REQ) && !redirect_valid && !rst;
    imem_addr      = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    if_id_free     = !id_valid || !stall;
    rsp_take       = (state == FS_WAIT) && imem_rsp_valid && !kill && !redirect_valid;
    buf_store      = rsp_take && !if_id_free;
    load           = (rsp_take && if_id_free) ||
                     ((state == FS_HOLD) && !stall && !redirect_valid);
    load_pc        = (state == FS_HOLD) ? buf_pc : inflight_pc;
    load_ir        = (state == FS_HOLD) ? buf_ir : imem_rsp_data;
  end

  // PC, kill flag and one-entry response buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= word_align(RESET_PC);
      inflight_pc <= 32'h0;
      kill        <= 1'b0;
      buf_pc      <= 32'h0;
      buf_ir      <= NOP_INSTR;
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
      kill     <= (state == FS_WAIT) && !imem_rsp_valid;
    end else begin
      if (req_fire) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (state == FS_WAIT && imem_rsp_valid) kill <= 1'b0;
      if (buf_store) begin
        buf_pc <= inflight_pc;
        buf_ir <= imem_rsp_data;
      end
    end
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .load       (load),
    .stall      (stall),
    .load_pc    (load_pc),
    .load_ir    (load_ir),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_ir      (id_ir)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_ir;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .id_ir         (id_ir)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];     // live responses not yet in IF/ID, in program order
  logic        outstanding = 1'b0;  // a request was accepted, response not yet seen
  logic        live = 1'b0;         // that response is still on the architectural path
  logic [31:0] out_pc = 32'h0;
  logic [31:0] exp_addr = RESET_PC;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_p4 = 32'h0;
  logic [31:0] rsp_addr = 32'h0;    // address the memory model answers for
  logic        accepted;
  int          wait_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: two fixed words from the test plan, hashed elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0008: return 32'h0020_8133;
      default:       return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive at the negedge, check the request side, advance the
  // model across the coming edge, then check IF/ID just after the edge.
  task automatic step(input logic s_rst, input logic s_stall, input logic s_redir,
                      input logic [31:0] s_rpc, input logic s_ready, input logic s_rsp);
    logic exp_req;
    rst            = s_rst;
    stall          = s_stall;
    redirect_valid = s_redir;
    redirect_pc    = s_rpc;
    imem_req_ready = s_ready;
    imem_rsp_valid = s_rsp;
    imem_rsp_data  = s_rsp ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
    #1;
    exp_req = !s_rst && !outstanding && (exp_q.size() == 0) && !s_redir;
    check("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_req});
    if (exp_req) check("req_addr", imem_addr, exp_addr);
    accepted = exp_req && s_ready;
    if (accepted) rsp_addr = imem_addr;

    if (s_rst) begin
      outstanding = 1'b0;
      live        = 1'b0;
      exp_q.delete();
      m_valid     = 1'b0;
      m_pc        = 32'h0;
      m_p4        = 32'h0;
      exp_addr    = RESET_PC;
    end else begin
      if (s_rsp && outstanding && live && !s_redir) exp_q.push_back(out_pc);
      if (s_rsp) outstanding = 1'b0;
      if (s_redir) begin
        exp_q.delete();
        live     = 1'b0;
        m_valid  = 1'b0;
        exp_addr = s_rpc & ~32'h3;
      end else if (exp_q.size() != 0 && (!m_valid || !s_stall)) begin
        m_pc    = exp_q.pop_front();
        m_p4    = m_pc + 32'd4;
        m_valid = 1'b1;
      end else if (!s_stall) begin
        m_valid = 1'b0;
      end
      if (accepted) begin
        out_pc      = exp_addr;
        exp_addr    = exp_addr + 32'd4;
        outstanding = 1'b1;
        live        = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    check("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
    check("id_pc", id_pc, m_pc);
    check("id_pc_plus4", id_pc_plus4, m_p4);
    check("id_ir", id_ir, m_valid ? mem_word(m_pc) : NOP);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    // reset
    step(1, 0, 0, 32'h0, 1, 0);
    step(1, 0, 0, 32'h0, 1, 0);
    check("rst_id_valid", {31'h0, id_valid}, 32'h0);
    check("rst_id_ir", id_ir, NOP);
    check("rst_id_pc_plus4", id_pc_plus4, 32'h0);

    // first fetches: addr 0, response one cycle later
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 1);
    check("tp_first_pc", id_pc, 32'h0);
    check("tp_first_ir", id_ir, 32'h0050_0093);
    check("tp_first_p4", id_pc_plus4, 32'h4);
    step(0, 0, 0, 32'h0, 1, 0);   // addr 4
    step(0, 0, 0, 32'h0, 1, 1);
    // stall held three cycles while addr 8 returns
    step(0, 1, 0, 32'h0, 1, 0);   // addr 8 issued, pc 4 held
    step(0, 1, 0, 32'h0, 1, 1);   // response parked
    step(0, 1, 0, 32'h0, 1, 0);
    check("tp_stall_hold_pc", id_pc, 32'h4);
    step(0, 0, 0, 32'h0, 1, 0);   // stall drops
    check("tp_unstall_pc", id_pc, 32'h8);
    check("tp_unstall_ir", id_ir, 32'h0020_8133);

    // redirect while waiting, response two cycles later is discarded
    step(0, 0, 0, 32'h0, 1, 0);   // addr 12
    step(0, 0, 1, 32'h0000_0103, 1, 0);
    check("tp_redir_valid", {31'h0, id_valid}, 32'h0);
    check("tp_redir_ir", id_ir, NOP);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 1);
    step(0, 0, 0, 32'h0, 1, 0);   // addr 0x100

    // redirect coincident with the response
    step(0, 0, 1, 32'h0000_0200, 1, 1);
    step(0, 0, 0, 32'h0, 1, 0);   // addr 0x200 immediately
    step(0, 0, 0, 32'h0, 1, 1);
    check("tp_after_coinc_pc", id_pc, 32'h200);

    // redirect and stall together: flush wins
    step(0, 1, 1, 32'h0000_0300, 1, 0);
    check("tp_flush_valid", {31'h0, id_valid}, 32'h0);
    check("tp_flush_ir", id_ir, 32'h0000_0013);

    // address wrap
    step(0, 0, 1, 32'hFFFF_FFFF, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0);   // addr FFFF_FFFC
    step(0, 0, 0, 32'h0, 1, 1);
    check("tp_wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("tp_wrap_p4", id_pc_plus4, 32'h0);
    step(0, 0, 0, 32'h0, 1, 0);   // addr 0 requested

    // reset during WAIT, then a late response
    step(1, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 1);
    check("tp_late_rsp_valid", {31'h0, id_valid}, 32'h0);
    check("tp_late_rsp_pc", id_pc, 32'h0);

    // randomized traffic
    wait_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_stall, r_redir, r_ready, r_rsp;
      logic [31:0] r_pc;
      r_rst   = ($urandom_range(0, 249) == 0);
      r_stall = ($urandom_range(0, 2) == 0);
      r_redir = ($urandom_range(0, 11) == 0);
      r_pc    = $urandom;
      r_ready = ($urandom_range(0, 3) != 0);
      r_rsp   = outstanding && (wait_cnt == 0);
      step(r_rst, r_stall, r_redir, r_pc, r_ready, r_rsp);
      if (accepted && !r_rst) wait_cnt = $urandom_range(0, 2);
      else if (wait_cnt > 0) wait_cnt--;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
